// File: rtl/product_pusher.sv
// Reads PAIRS operand pairs (A at i, B at B_BASE+i), multiplies them and pushes the low 32 bits to a FIFO.
// Optional macro MULT_FAST_EN selects a single-cycle multiplier; otherwise a 32-cycle shift-add unit is built.
module product_pusher #(
    parameter int         PAIRS  = 8,
    parameter logic [3:0] B_BASE = 4'd8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        opstart,
    input  logic        opclear,
    input  logic [31:0] rData,
    input  logic        fifo_full,
    output logic        RF_re,
    output logic [3:0]  rAddr,
    output logic        fifo_we,
    output logic [31:0] fifo_din,
    output logic        opdone
);

    typedef enum logic [2:0] {IDLE, RDA, RDB, LATB, MUL, PUSH, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  idx;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [31:0] product;
    logic        mul_last;

    function automatic logic [31:0] mul_lo(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] full;
        full = {32'd0, x} * {32'd0, y};
        return full[31:0];
    endfunction

    function automatic logic [31:0] partial(input logic [31:0] mcand, input logic mbit);
        return mbit ? mcand : 32'd0;
    endfunction

`ifdef MULT_FAST_EN
    assign mul_last = 1'b1;
`else
    logic [31:0] acc;
    logic [4:0]  cnt;
    logic [31:0] acc_nxt;

    assign mul_last = (cnt == 5'd31);
    assign acc_nxt  = acc + partial(a_reg, b_reg[0]);
`endif

    always_comb begin
        state_nxt = state;
        RF_re     = 1'b0;
        rAddr     = 4'd0;
        fifo_we   = 1'b0;
        case (state)
            IDLE: if (opstart) state_nxt = RDA;
            RDA: begin
                RF_re     = 1'b1;
                rAddr     = idx;
                state_nxt = RDB;
            end
            RDB: begin
                RF_re     = 1'b1;
                rAddr     = B_BASE + idx;
                state_nxt = LATB;
            end
            LATB: state_nxt = MUL;
            MUL:  if (mul_last) state_nxt = PUSH;
            PUSH: begin
                if (!fifo_full) begin
                    fifo_we   = 1'b1;
                    state_nxt = ((int'(idx) + 1) < PAIRS) ? RDA : DONE;
                end
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
        // Abort and reset suppress strobes in the very cycle they are seen.
        if (opclear || reset) begin
            state_nxt = IDLE;
            RF_re     = 1'b0;
            rAddr     = 4'd0;
            fifo_we   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= 4'd0;
            a_reg   <= 32'd0;
            b_reg   <= 32'd0;
            product <= 32'd0;
`ifndef MULT_FAST_EN
            acc     <= 32'd0;
            cnt     <= 5'd0;
`endif
        end else begin
            state <= state_nxt;
            if (state == IDLE && opstart) idx <= 4'd0;
            if (fifo_we) idx <= idx + 4'd1;
            if (state == RDB) a_reg <= rData;
            if (state == LATB) b_reg <= rData;
`ifdef MULT_FAST_EN
            if (state == MUL) product <= mul_lo(a_reg, b_reg);
`else
            if (state == LATB) begin
                acc <= 32'd0;
                cnt <= 5'd0;
            end
            // Shift-add consumes A and B in place: A walks left, B walks right.
            if (state == MUL) begin
                cnt   <= cnt + 5'd1;
                acc   <= acc_nxt;
                a_reg <= a_reg << 1;
                b_reg <= b_reg >> 1;
                if (mul_last) product <= acc_nxt;
            end
`endif
        end
    end

    assign fifo_din = product;
    assign opdone   = (state == DONE);

endmodule

// File: tb/tb_product_pusher.sv
// Bench for product_pusher: register-file model, random operands, stall/abort/reset scenarios.
module tb_product_pusher;

    localparam int         PAIRS  = 8;
    localparam logic [3:0] B_BASE = 4'd8;
`ifdef MULT_FAST_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 35;
`endif
    localparam int RUN_LIMIT = PAIRS * (LAT + 1) * 4 + 100;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        opstart   = 1'b0;
    logic        opclear   = 1'b0;
    logic        fifo_full = 1'b0;
    logic [31:0] rData     = 32'd0;
    logic        RF_re;
    logic [3:0]  rAddr;
    logic        fifo_we;
    logic [31:0] fifo_din;
    logic        opdone;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    logic [31:0] rf [16];
    logic [31:0] obs_q [$];
    int          we_cyc [$];
    int          rda_cyc [$];

    product_pusher #(.PAIRS(PAIRS), .B_BASE(B_BASE)) dut (
        .clk(clk), .reset(reset), .opstart(opstart), .opclear(opclear),
        .rData(rData), .fifo_full(fifo_full), .RF_re(RF_re), .rAddr(rAddr),
        .fifo_we(fifo_we), .fifo_din(fifo_din), .opdone(opdone)
    );

    always #5 clk = ~clk;

    // Register file answers one cycle after the strobe; garbage otherwise.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rData <= RF_re ? rf[rAddr] : $urandom;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (fifo_we) begin
            obs_q.push_back(fifo_din);
            we_cyc.push_back(cyc);
        end
        if (RF_re && rAddr < B_BASE) rda_cyc.push_back(cyc);
        check("we_while_full", 32'(fifo_we & fifo_full), 32'd0);
        check("re_with_we", 32'(RF_re & fifo_we), 32'd0);
        check("addr_idle", 32'(RF_re ? 4'd0 : rAddr), 32'd0);
    end

    function automatic logic [31:0] expect_prod(input int k);
        logic [63:0] p;
        p = 64'(rf[k]) * 64'(rf[(int'(B_BASE) + k) % 16]);
        return p[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        tick();
        opstart = 1'b1;
        tick();
        opstart = 1'b0;
    endtask

    task automatic pulse_clear();
        tick();
        opclear = 1'b1;
        tick();
        opclear = 1'b0;
    endtask

    task automatic clear_q();
        obs_q.delete();
        we_cyc.delete();
        rda_cyc.delete();
    endtask

    task automatic load_rand();
        for (int k = 0; k < 16; k++) rf[k] = $urandom;
    endtask

    task automatic wait_done(input int limit, input bit rand_full);
        int n = 0;
        while (!opdone && n < limit) begin
            if (rand_full) fifo_full = ($urandom_range(0, 3) == 0);
            tick();
            n++;
        end
        fifo_full = 1'b0;
        check("done_reached", 32'(opdone), 32'd1);
    endtask

    task automatic check_writes(input string tag, input int n);
        check($sformatf("%s_count", tag), obs_q.size(), n);
        for (int k = 0; k < n && k < obs_q.size(); k++)
            check($sformatf("%s_w%0d", tag, k), obs_q[k], expect_prod(k));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 16; k++) rf[k] = 32'd0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_re", 32'(RF_re), 32'd0);
        check("rst_addr", 32'(rAddr), 32'd0);
        check("rst_we", 32'(fifo_we), 32'd0);
        check("rst_din", fifo_din, 32'd0);
        check("rst_done", 32'(opdone), 32'd0);
        tick();
        reset = 1'b0;

        // Ramp operands times two, no back-pressure
        for (int k = 0; k < 8; k++) begin
            rf[k]     = 32'(k + 1);
            rf[k + 8] = 32'd2;
        end
        clear_q();
        pulse_start();
        wait_done(RUN_LIMIT, 1'b0);
        check_writes("basic", PAIRS);
        if (obs_q.size() == PAIRS) check("basic_last", obs_q[PAIRS-1], 32'd16);
        for (int k = 0; k < PAIRS; k++)
            if (k < we_cyc.size() && k < rda_cyc.size())
                check($sformatf("lat_p%0d", k), 32'(we_cyc[k] - rda_cyc[k]), 32'(LAT));

        // DONE holds and ignores opstart
        pulse_start();
        repeat (5) tick();
        @(negedge clk);
        check("done_hold", 32'(opdone), 32'd1);
        check("done_re", 32'(RF_re), 32'd0);
        check("done_nowrite", obs_q.size(), PAIRS);
        pulse_clear();
        @(negedge clk);
        check("clear_done", 32'(opdone), 32'd0);

        // Truncation of the upper product bits
        load_rand();
        rf[0] = 32'hFFFF_FFFF;
        rf[8] = 32'd2;
        clear_q();
        pulse_start();
        wait_done(RUN_LIMIT, 1'b0);
        check_writes("trunc", PAIRS);
        if (obs_q.size() > 0) check("trunc_w0", obs_q[0], 32'hFFFF_FFFE);
        pulse_clear();

        // FIFO full for 10 cycles on the first PUSH
        load_rand();
        clear_q();
        fifo_full = 1'b1;
        pulse_start();
        repeat (LAT) tick();
        @(negedge clk);
        check("stall_we0", 32'(fifo_we), 32'd0);
        check("stall_din", fifo_din, expect_prod(0));
        for (int c = 1; c < 10; c++) begin
            tick();
            @(negedge clk);
            check($sformatf("stall_we%0d", c), 32'(fifo_we), 32'd0);
            check($sformatf("stall_din%0d", c), fifo_din, expect_prod(0));
        end
        tick();
        fifo_full = 1'b0;
        @(negedge clk);
        check("stall_release_we", 32'(fifo_we), 32'd1);
        wait_done(RUN_LIMIT, 1'b0);
        check_writes("stall", PAIRS);
        pulse_clear();

        // Abort while pair 3 is multiplying
        load_rand();
        clear_q();
        pulse_start();
        repeat (3 * (LAT + 1) + 3) tick();
        opclear = 1'b1;
        @(negedge clk);
        check("abort_re", 32'(RF_re), 32'd0);
        check("abort_we", 32'(fifo_we), 32'd0);
        tick();
        opclear = 1'b0;
        repeat (LAT + 5) tick();
        @(negedge clk);
        check("abort_done", 32'(opdone), 32'd0);
        check_writes("abort", 3);
        clear_q();
        pulse_start();
        @(negedge clk);
        check("restart_re", 32'(RF_re), 32'd1);
        check("restart_addr", 32'(rAddr), 32'd0);
        wait_done(RUN_LIMIT, 1'b0);
        check_writes("restart", PAIRS);
        pulse_clear();

        // Random operands with random back-pressure
        for (int r = 0; r < 3; r++) begin
            load_rand();
            clear_q();
            pulse_start();
            wait_done(RUN_LIMIT, 1'b1);
            check_writes($sformatf("rand%0d", r), PAIRS);
            pulse_clear();
        end

        // Reset during the first PUSH
        load_rand();
        clear_q();
        pulse_start();
        repeat (LAT) tick();
        reset = 1'b1;
        @(negedge clk);
        check("rstpush_we", 32'(fifo_we), 32'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rstpush_re", 32'(RF_re), 32'd0);
        check("rstpush_addr", 32'(rAddr), 32'd0);
        check("rstpush_we1", 32'(fifo_we), 32'd0);
        check("rstpush_din", fifo_din, 32'd0);
        check("rstpush_done", 32'(opdone), 32'd0);
        repeat (10) tick();
        check("rstpush_nowrite", obs_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/product_pusher.md
PRODUCT_PUSHER -- requirements
Module: product_pusher

Interface
REQ-001 Parameter PAIRS, default 8, meaning number of operand pairs processed per operation (1..8).
REQ-002 Parameter B_BASE, default 4'd8, meaning register-file address of the first B operand; A operands start at address 0.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 opstart  input  1  level; starts an operation when sampled high in IDLE.
REQ-006 opclear  input  1  abort; returns block to IDLE from any state.
REQ-007 rData  input  32  register-file read data, valid the cycle after RF_re with rAddr.
REQ-008 fifo_full  input  1  downstream FIFO cannot accept a write this cycle.
REQ-009 RF_re  output  1  register-file read strobe.
REQ-010 rAddr  output  4  register-file read address.
REQ-011 fifo_we  output  1  FIFO write strobe, one cycle per product.
REQ-012 fifo_din  output  32  product written to FIFO; valid while fifo_we high.
REQ-013 opdone  output  1  level; high in DONE.

Function
REQ-014 FSM states SHALL be IDLE, RDA, RDB, LATB, MUL, PUSH, DONE.
REQ-015 IDLE -> RDA on opstart; pair index i cleared to 0.
REQ-016 RDA: RF_re=1, rAddr=i; next RDB.
REQ-017 RDB: RF_re=1, rAddr=B_BASE+i (4-bit wrap); capture rData as A; next LATB.
REQ-018 LATB: capture rData as B; next MUL.
REQ-019 MUL: product = low 32 bits of A*B (unsigned, upper bits discarded); next PUSH when product ready.
REQ-020 PUSH: if fifo_full, hold with fifo_we=0 and fifo_din stable; else fifo_we=1 for exactly one cycle, then i+1; next RDA if i+1<PAIRS else DONE.
REQ-021 DONE: opdone=1; stays until opclear; opstart ignored.
REQ-022 opclear in any state SHALL force IDLE next cycle with no further RF_re/fifo_we; opclear has priority over opstart and fifo_full.
REQ-023 fifo_we SHALL never be high while fifo_full is high.
REQ-024 RF_re and fifo_we SHALL never be high in the same cycle.
REQ-025 rAddr SHALL be 0 whenever RF_re is 0.
REQ-026 Exactly PAIRS FIFO writes SHALL occur per uninterrupted operation, in index order.

Reset
REQ-027 On reset: state IDLE, i=0, A=B=product=0, RF_re=0, rAddr=0, fifo_we=0, fifo_din=0, opdone=0.
REQ-028 Reset mid-operation SHALL abandon the pair in progress; no FIFO write in the reset cycle or after it until a new opstart.

Configuration
REQ-029 Macro MULT_FAST_EN defined: MUL lasts exactly 1 cycle (single-cycle combinational multiply); per-pair latency RDA->first PUSH cycle = 4 cycles.
REQ-030 MULT_FAST_EN undefined: MUL is an iterative shift-add multiplier, exactly 32 cycles in MUL; per-pair latency = 35 cycles; results identical to fast mode.

Verification
REQ-031 Reset, then RF[0..7]=1..8, RF[8..15]=2, opstart pulse, fifo_full=0 -> 8 writes 2,4,6,...,16 in order, then opdone=1.
REQ-032 RF[0]=32'hFFFF_FFFF, RF[8]=2, PAIRS=1 -> single write 32'hFFFF_FFFE (truncation).
REQ-033 fifo_full high for 10 cycles on first PUSH -> fifo_we stays 0, fifo_din stable, write occurs the cycle after fifo_full drops; total writes still 8.
REQ-034 opclear asserted in MUL of pair 3 -> IDLE next cycle, only 3 writes seen, opdone=0; new opstart restarts at rAddr=0.
REQ-035 reset asserted in PUSH with fifo_full=0 -> no fifo_we that cycle, all outputs at reset values next cycle.
REQ-036 Run REQ-031 with and without MULT_FAST_EN -> identical write sequence; cycles per pair 4 vs 35 (RDA to PUSH).
